// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequenced carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CHUNK_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Carry out of a 4-bit group given its generate/propagate and carry-in.
  function automatic logic grp_carry(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Pure-combinational 4-bit carry-lookahead slice.
module cla4_slice (
  input  logic       cin,
  input  logic [3:0] p,
  input  logic [3:0] g,
  output logic       grp_g,
  output logic       grp_p,
  output logic [2:0] cout
);

  always_comb begin
    cout[0] = g[0] | (p[0] & cin);
    cout[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    cout[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grp_g   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p   = &p;
  end

endmodule

// File: rtl/cla_add_seq.sv
// Multi-cycle wide adder: one shared 4-bit lookahead slice, LSB-first, one chunk per cycle.
// Optional macro CLA_ADD_SEQ_SUB_EN adds a sub port for a - b.
module cla_add_seq
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t state_q, state_d;

  logic [NCHUNK-1:0][CHUNK_W-1:0] a_q, b_q, sum_q;
  logic                           c_q;
  logic [KW-1:0]                  k_q;

  logic [CHUNK_W-1:0] a_k, b_k, sum_k;
  logic [CHUNK_W-1:0] bit_c;
  logic [2:0]         slice_cout;
  logic               grp_g, grp_p, c_next;
  logic               accept, last;

  // Chunk mux into the single shared slice.
  assign a_k    = a_q[k_q];
  assign b_k    = b_q[k_q];
  assign accept = (state_q == IDLE) && in_valid;
  assign last   = (k_q == KW'(NCHUNK - 1));

  cla4_slice u_slice (
    .cin   (c_q),
    .p     (a_k | b_k),
    .g     (a_k & b_k),
    .grp_g (grp_g),
    .grp_p (grp_p),
    .cout  (slice_cout)
  );

  assign bit_c  = {slice_cout, c_q};
  assign sum_k  = a_k ^ b_k ^ bit_c;
  assign c_next = grp_carry(grp_g, grp_p, c_q);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Operand capture and per-chunk datapath.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      k_q   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q <= a;
`ifdef CLA_ADD_SEQ_SUB_EN
      b_q <= sub ? ~b : b;
      c_q <= sub ? 1'b1 : cin;
`else
      b_q <= b;
      c_q <= cin;
`endif
      k_q <= '0;
    end else if (state_q == RUN) begin
      sum_q[k_q] <= sum_k;
      c_q        <= c_next;
      k_q        <= k_q + KW'(1);
      if (last) cout <= c_next;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_cla_add_seq.sv
// Randomized self-checking bench for cla_add_seq against an arithmetic reference.
module tb_cla_add_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NCHUNK = WIDTH / 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, cout, busy;
`ifdef CLA_ADD_SEQ_SUB_EN
  logic             sub;
`endif

  int checks = 0;
  int errors = 0;

  cla_add_seq #(.WIDTH(WIDTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_ADD_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, stall, retire.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic ts, input int stall);
    logic [WIDTH:0] expv;
    int n;
    if (ts) expv = {1'b0, ta} + {1'b0, ~tb} + (WIDTH+1)'(1);
    else    expv = {1'b0, ta} + {1'b0, tb} + (WIDTH+1)'(tc);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
`ifdef CLA_ADD_SEQ_SUB_EN
    sub = ts;
`endif
    tick;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef CLA_ADD_SEQ_SUB_EN
    sub = 1'($urandom);
`endif
    check("run_busy", 32'(busy), 32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      tick;
      if (!out_valid) n++;
    end
    check("latency", 32'(n), 32'(NCHUNK));
    check("sum", 32'(sum), 32'(expv[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(expv[WIDTH]));
    for (int i = 0; i < stall; i++) begin
      tick;
      check("hold_sum", 32'(sum), 32'(expv[WIDTH-1:0]));
      check("hold_cout", 32'(cout), 32'(expv[WIDTH]));
      check("hold_flags", {29'd0, out_valid, in_ready, busy}, 32'b101);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("retire_flags", {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef CLA_ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    tick; tick;
    check("rst_flags", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    sys_rst = 1'b0;
    tick;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 5);

    // Stray out_ready while idle must not disturb anything.
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("idle_out_ready", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // Reset in the second RUN cycle aborts the operation.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    check("abort_flags", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef CLA_ADD_SEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 2);
`endif

    for (int t = 0; t < 40; t++) begin
      logic s;
`ifdef CLA_ADD_SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
